// File: rtl/monolith_axis_chunk_stream_master.sv
`default_nettype none
// ============================================================================
// Module   : monolith_axis_chunk_stream_master
// Purpose  : Chunk-write FIFO feeding an AXI4-Stream master port. A producer
//            deposits CHUNK_SIZE words in one cycle. The block streams them
//            out one word per cycle through a fully registered output stage.
//            TLAST marks every CHUNK_SIZE*CHUNKS_PER_PACKET-th word.
// Ports    : M_AXIS_ACLK / M_AXIS_ARESET - clock, synchronous active-high reset
//            chunk_wr_strobe, chunk_in   - chunk write (word 0 in the LSBs)
//            chunk_wr_ready              - a free slot exists
//            flush                       - discard all queued chunks
//            fifo_level                  - chunks not yet fully loaded out
//            overflow                    - sticky, strobe seen while full
//            M_AXIS_*                    - AXI4-Stream master
//            stat_* (optional)           - saturating statistics counters
// Options  : define MONOLITH_AXIS_CHUNK_STATS_EN to add the stat_* counters
// Revision : 1.0 - initial release
// ============================================================================
module monolith_axis_chunk_stream_master #(
    parameter int TDATA_WIDTH       = 32,
    parameter int CHUNK_SIZE        = 16,
    parameter int CHUNK_COUNT       = 4,
    parameter int CHUNKS_PER_PACKET = 1
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESET,
    input  logic                              chunk_wr_strobe,
    input  logic [TDATA_WIDTH*CHUNK_SIZE-1:0] chunk_in,
    output logic                              chunk_wr_ready,
    input  logic                              flush,
    output logic [$clog2(CHUNK_COUNT):0]      fifo_level,
    output logic                              overflow,
    output logic                              M_AXIS_TVALID,
    output logic [TDATA_WIDTH-1:0]            M_AXIS_TDATA,
    output logic [TDATA_WIDTH/8-1:0]          M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
`ifdef MONOLITH_AXIS_CHUNK_STATS_EN
    ,
    output logic [31:0]                       stat_packets,
    output logic [31:0]                       stat_stall_cycles,
    output logic [31:0]                       stat_dropped_chunks
`endif
);

    localparam int c_IDX_W     = $clog2(CHUNK_COUNT);
    localparam int c_PTR_W     = c_IDX_W + 1;
    localparam int c_LVL_W     = c_IDX_W + 1;
    localparam int c_WIDX_W    = $clog2(CHUNK_SIZE);
    localparam int c_PKT_WORDS = CHUNK_SIZE * CHUNKS_PER_PACKET;
    localparam int c_PCNT_W    = $clog2(c_PKT_WORDS);

    localparam logic [c_WIDX_W-1:0] c_WIDX_LAST = c_WIDX_W'(CHUNK_SIZE - 1);
    localparam logic [c_PCNT_W-1:0] c_PCNT_LAST = c_PCNT_W'(c_PKT_WORDS - 1);

    localparam logic [0:0] c_OUT_EMPTY = 1'b0;
    localparam logic [0:0] c_OUT_VALID = 1'b1;

    // Chunk storage, one full chunk per slot
    logic [TDATA_WIDTH*CHUNK_SIZE-1:0] r_mem [CHUNK_COUNT];

    logic [c_PTR_W-1:0]     r_wp;
    logic [c_PTR_W-1:0]     r_rp;
    logic [c_WIDX_W-1:0]    r_widx;
    logic [c_PCNT_W-1:0]    r_pcnt;
    logic [c_LVL_W-1:0]     r_level;
    logic                   r_overflow;
    logic [0:0]             r_state;
    logic [TDATA_WIDTH-1:0] r_tdata;
    logic                   r_tlast;

    logic [0:0]             w_next_state;
    logic                   w_load;
    logic                   w_free;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_ready;
    logic                   w_wr_accept;
    logic                   w_tlast_next;
    logic [TDATA_WIDTH-1:0] w_word;

    // Extra wrap bit: equal pointers mean empty, index match with differing
    // wrap bits means full.
    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[c_IDX_W] != r_rp[c_IDX_W]) &&
                     (r_wp[c_IDX_W-1:0] == r_rp[c_IDX_W-1:0]);

    assign w_ready     = !w_full && !M_AXIS_ARESET;
    // A write coinciding with flush would land behind the new read pointer
    // and survive the flush, so it is dropped instead.
    assign w_wr_accept = chunk_wr_strobe && w_ready && !flush;

    assign w_word       = r_mem[r_rp[c_IDX_W-1:0]][r_widx*TDATA_WIDTH +: TDATA_WIDTH];
    assign w_tlast_next = (r_pcnt == c_PCNT_LAST);
    assign w_free       = w_load && (r_widx == c_WIDX_LAST);

    // Output stage next-state. Loading is suppressed while flushing so the
    // discarded queue never reaches the output register.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            c_OUT_EMPTY: begin
                if (!w_empty && !flush) begin
                    w_load       = 1'b1;
                    w_next_state = c_OUT_VALID;
                end
            end
            c_OUT_VALID: begin
                if (M_AXIS_TREADY) begin
                    if (!w_empty && !flush) begin
                        w_load = 1'b1;
                    end else begin
                        w_next_state = c_OUT_EMPTY;
                    end
                end
            end
            default: begin
                w_next_state = c_OUT_EMPTY;
            end
        endcase
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_state <= c_OUT_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (w_wr_accept) begin
            r_mem[r_wp[c_IDX_W-1:0]] <= chunk_in;
        end
    end

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_widx     <= '0;
            r_pcnt     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_tdata    <= '0;
            r_tlast    <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wp <= r_wp + c_PTR_W'(1);
            end

            if (w_load) begin
                r_tdata <= w_word;
                r_tlast <= w_tlast_next;
                r_pcnt  <= w_tlast_next ? '0 : r_pcnt + c_PCNT_W'(1);
                r_widx  <= w_free ? '0 : r_widx + c_WIDX_W'(1);
                if (w_free) begin
                    r_rp <= r_rp + c_PTR_W'(1);
                end
            end

            // The word already in the output register keeps its TLAST;
            // only the queue and packet position are discarded.
            if (flush) begin
                r_rp   <= r_wp;
                r_widx <= '0;
                r_pcnt <= '0;
            end

            if (flush) begin
                r_level <= '0;
            end else if (w_wr_accept && !w_free) begin
                r_level <= r_level + c_LVL_W'(1);
            end else if (!w_wr_accept && w_free) begin
                r_level <= r_level - c_LVL_W'(1);
            end

            if (flush) begin
                r_overflow <= 1'b0;
            end else if (chunk_wr_strobe && !w_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign chunk_wr_ready = w_ready;
    assign fifo_level     = r_level;
    assign overflow       = r_overflow;
    assign M_AXIS_TVALID  = (r_state == c_OUT_VALID);
    assign M_AXIS_TDATA   = r_tdata;
    assign M_AXIS_TLAST   = r_tlast;
    assign M_AXIS_TSTRB   = '1;

`ifdef MONOLITH_AXIS_CHUNK_STATS_EN
    logic [31:0] r_stat_packets;
    logic [31:0] r_stat_stall;
    logic [31:0] r_stat_dropped;
    logic        w_tvalid;

    assign w_tvalid = (r_state == c_OUT_VALID);

    always_ff @(posedge M_AXIS_ACLK) begin
        if (M_AXIS_ARESET) begin
            r_stat_packets <= '0;
            r_stat_stall   <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_tvalid && M_AXIS_TREADY && r_tlast && (r_stat_packets != '1)) begin
                r_stat_packets <= r_stat_packets + 32'd1;
            end
            if (w_tvalid && !M_AXIS_TREADY && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
            if (chunk_wr_strobe && w_full && (r_stat_dropped != '1)) begin
                r_stat_dropped <= r_stat_dropped + 32'd1;
            end
        end
    end

    assign stat_packets        = r_stat_packets;
    assign stat_stall_cycles   = r_stat_stall;
    assign stat_dropped_chunks = r_stat_dropped;
`endif

endmodule
`default_nettype wire

// File: doc/monolith_axis_chunk_stream_master.md
Name: monolith_axis_chunk_stream_master

Overview:
- Parametrised chunk-write FIFO feeding an AXI4-Stream master port.
- Producer writes whole chunks of CHUNK_SIZE words in one cycle; block streams them out word-by-word at up to 1 word/cycle.
- Output is fully registered, TVALID/TDATA are held stable under backpressure, and TLAST marks configurable packet boundaries.
- Sits between the Monolith compute core and the DMA S2MM stream input on the Zynq PL side.

Parameters:
TDATA_WIDTH, 32, stream word width in bits; multiple of 8.
CHUNK_SIZE, 16, words per chunk; power of 2, >=2.
CHUNK_COUNT, 4, chunk slots in storage; power of 2, >=2.
CHUNKS_PER_PACKET, 1, chunks per AXIS packet; TLAST on the last word of each packet; >=1.

Ports:
M_AXIS_ACLK  in  1  single clock.
M_AXIS_ARESET  in  1  synchronous, active-high reset.
chunk_wr_strobe  in  1  write one chunk this cycle.
chunk_in  in  TDATA_WIDTH*CHUNK_SIZE  chunk payload, flattened; word 0 in LSBs, streamed first.
chunk_wr_ready  out  1  slot available; write is accepted only when high.
flush  in  1  discard all queued chunks.
fifo_level  out  $clog2(CHUNK_COUNT)+1  queued chunks not yet fully loaded into the output register.
overflow  out  1  sticky; set when a strobe arrives with chunk_wr_ready low.
M_AXIS_TVALID  out  1  AXIS valid.
M_AXIS_TDATA  out  TDATA_WIDTH  AXIS data.
M_AXIS_TSTRB  out  TDATA_WIDTH/8  constant all-ones.
M_AXIS_TLAST  out  1  packet boundary.
M_AXIS_TREADY  in  1  AXIS ready.

Behaviour:
- Reset values: TVALID=0, TDATA=0, TLAST=0, fifo_level=0, overflow=0; all pointers and counters are 0.
- chunk_wr_ready = !full && !M_AXIS_ARESET. Full means fifo_level==CHUNK_COUNT.
- Write and read chunk pointers carry an extra wrap bit; empty/full are decided by comparing the MSB and the index bits. Pointers wrap modulo 2*CHUNK_COUNT.
- Accepted write (strobe && ready): chunk stored at slot wp, wp+1.
- Strobe while full: chunk dropped, wp unchanged, overflow<=1.
- Output stage FSM:
  - OUT_EMPTY: TVALID=0. If FIFO is non-empty, load word[rp][widx], go to OUT_VALID.
  - OUT_VALID: TVALID=1. On handshake (TVALID&&TREADY), load the next word if available (stay), else go to OUT_EMPTY. Without a handshake, TDATA/TLAST are held unchanged.
- Word index widx advances on each load. Loading word CHUNK_SIZE-1 frees the slot: rp+1, widx=0.
- fifo_level is updated each cycle by +write −free. When a write and a free coincide, level is unchanged.
- A write when full in the same cycle as a free is NOT accepted, because ready is derived from the pre-edge level.
- Latency: chunk accepted at edge E0 -> TVALID=1 with word 0 after edge E1 (when output was empty).
- With TREADY held high, back-to-back chunks stream with no bubble: 1 word/cycle.
- TLAST: packet word counter pcnt, width $clog2(CHUNK_SIZE*CHUNKS_PER_PACKET), counts loaded words.
  - Loaded TLAST=1 iff pcnt==CHUNK_SIZE*CHUNKS_PER_PACKET-1.
  - pcnt then wraps to 0.
- flush:
  - Sets rp=wp, widx=0, pcnt=0, fifo_level=0, overflow=0.
  - A word already in OUT_VALID stays valid with its registered TLAST until its handshake, then the FSM goes to OUT_EMPTY.
  - A write in the same cycle as flush is discarded.
- Reset mid-packet: returns to the reset state immediately; a partial packet is lost; TVALID drops in the next cycle.
- No combinational path from M_AXIS_TREADY to TDATA/TVALID/TLAST.

Optional Feature:
Macro MONOLITH_AXIS_CHUNK_STATS_EN.
- Defined: adds three 32-bit output counters, saturating, cleared by reset only:
  - stat_packets: +1 per TLAST handshake.
  - stat_stall_cycles: +1 per cycle with TVALID && !TREADY.
  - stat_dropped_chunks: +1 per strobe rejected while full.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Defaults; write one chunk of 0..15 at E0, TREADY=1 -> TVALID rises after E1; TDATA 0..15 on consecutive cycles; TLAST only with 15; fifo_level 1->0 after word 15 loads.
- CHUNK_SIZE=4, CHUNK_COUNT=2, CHUNKS_PER_PACKET=2; write chunks A0..A3, B0..B3 back-to-back, TREADY=1 -> 8 contiguous beats, TLAST only on B3.
- Defaults; fill 4 chunks with TREADY=0, then strobe again -> chunk_wr_ready=0, overflow=1, level stays 4; then TREADY=1 -> 64 words out in order, the 5th chunk never appears.
- Random TREADY (50%) over 8 chunks -> TDATA/TLAST stable during every stall; received sequence equals sent sequence; TLAST every 16 words.
- Level full (4) with TREADY=1 during the free cycle plus a simultaneous strobe -> strobe rejected, overflow=1; strobe one cycle later -> accepted.
- Flush with 3 chunks queued and TVALID=1, TREADY=0 -> current word held until TREADY=1, then TVALID=0, level=0; next written chunk starts with pcnt=0, so TLAST lands on its word 15.
